// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU BIST: op encodings, controller states,
// first-failure record and the golden reference function.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  localparam int          IDX_W    = 11;
  localparam logic [10:0] IDX_LAST = 11'h7ff;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] y;
  } fail_rec_t;

  // All results are mod 16; shifts drop the outgoing bit and shift in zero.
  function automatic logic [3:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
    logic [3:0] r;
    r = 4'd0;
    case (op)
      OP_ADD: r = a + b;
      OP_SUB: r = a - b;
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~a;
      OP_SHL: r = {a[2:0], 1'b0};
      OP_SHR: r = {1'b0, a[3:1]};
      default: r = 4'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_golden.sv
// Combinational golden ALU model; wraps alu_ref so the controller and
// benches share a single definition of correct behaviour.
module alu_golden
  import alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] op,
  output logic [3:0] y
);

  assign y = alu_ref(a, b, op);

endmodule

// File: rtl/alu_bist_ctrl.sv
// Closed-loop BIST for the 4-bit ALU: sweeps all {A,B,op} vectors, checks Y
// against the golden model, counts mismatches and records the first failure.
module alu_bist_ctrl
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,   // legal range 1..15
  parameter int ERR_W         = 12,
  parameter bit STOP_ON_FAIL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_a,
  output logic [3:0]       fail_b,
  output logic [2:0]       fail_op,
  output logic [3:0]       fail_y,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_op,
  input  logic [3:0]       alu_y
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  bist_state_t      state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [3:0]       scnt;
  logic [ERR_W-1:0] err_q;
  fail_rec_t        fail_q;

  logic [3:0] gold_y;
  logic       launch, settle_end, mismatch, last_vec, finish;

  // Stimulus comes straight from the index register, so it cannot glitch
  // while the ALU output settles.
  assign alu_op = idx[2:0];
  assign alu_b  = idx[6:3];
  assign alu_a  = idx[10:7];

  alu_golden u_gold (
    .a  (alu_a),
    .b  (alu_b),
    .op (alu_op),
    .y  (gold_y)
  );

  assign launch     = start && (state == ST_IDLE || state == ST_DONE);
  assign settle_end = (scnt == SETTLE_LAST);
  assign mismatch   = (alu_y != gold_y);
  assign last_vec   = (idx == IDX_LAST);
  assign finish     = last_vec || (STOP_ON_FAIL && mismatch);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start)      state_nxt = ST_APPLY;
      ST_APPLY: if (settle_end) state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = finish ? ST_DONE : ST_APPLY;
      ST_DONE:  if (start)      state_nxt = ST_APPLY;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_APPLY) || (state == ST_CHECK);
    done = (state == ST_DONE);
    pass = done && (err_q == '0);
  end

  // Vector index, settle timer, error counter and first-failure capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      scnt   <= '0;
      err_q  <= '0;
      fail_q <= '0;
    end else if (launch) begin
      idx    <= '0;
      scnt   <= '0;
      err_q  <= '0;
      fail_q <= '0;
    end else begin
      case (state)
        ST_APPLY: scnt <= settle_end ? 4'd0 : scnt + 4'd1;
        ST_CHECK: begin
          if (mismatch) begin
            if (err_q != '1) err_q <= err_q + 1'b1;
            // A zero count means nothing has failed yet in this run.
            if (err_q == '0) fail_q <= '{a: alu_a, b: alu_b, op: alu_op, y: alu_y};
          end
          if (!finish) idx <= idx + 11'd1;
        end
        default: ;
      endcase
    end
  end

  assign err_count = err_q;
  assign fail_a    = fail_q.a;
  assign fail_b    = fail_q.b;
  assign fail_op   = fail_q.op;
  assign fail_y    = fail_q.y;

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Self-checking bench: three controllers (settle 1, settle 1 + stop-on-fail,
// settle 3) against a bench-side ALU with an optional SUB->ADD fault.
module tb_alu_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       fault = 1'b0;
  logic [2:0] start = 3'b000;

  logic        busy [3];
  logic        done [3];
  logic        pass [3];
  logic [11:0] err  [3];
  logic [3:0]  fa [3], fb [3], fy [3], aa [3], ab [3], ay [3];
  logic [2:0]  fop [3], aop [3];

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] tb_ref(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] op);
    logic [3:0] r;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: r = {a[2:0], 1'b0};
      default: r = {1'b0, a[3:1]};
    endcase
    return r;
  endfunction

  function automatic logic [3:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] op, input logic flt);
    logic [3:0] s;
    s = a + b;
    return (flt && op == 3'd1) ? s : tb_ref(a, b, op);
  endfunction

  assign ay[0] = alu_model(aa[0], ab[0], aop[0], fault);
  assign ay[1] = alu_model(aa[1], ab[1], aop[1], fault);
  assign ay[2] = alu_model(aa[2], ab[2], aop[2], fault);

  alu_bist_ctrl #(.SETTLE_CYCLES(1), .ERR_W(12), .STOP_ON_FAIL(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .err_count(err[0]), .fail_a(fa[0]), .fail_b(fb[0]),
    .fail_op(fop[0]), .fail_y(fy[0]), .alu_a(aa[0]), .alu_b(ab[0]),
    .alu_op(aop[0]), .alu_y(ay[0]));

  alu_bist_ctrl #(.SETTLE_CYCLES(1), .ERR_W(12), .STOP_ON_FAIL(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .err_count(err[1]), .fail_a(fa[1]), .fail_b(fb[1]),
    .fail_op(fop[1]), .fail_y(fy[1]), .alu_a(aa[1]), .alu_b(ab[1]),
    .alu_op(aop[1]), .alu_y(ay[1]));

  alu_bist_ctrl #(.SETTLE_CYCLES(3), .ERR_W(12), .STOP_ON_FAIL(1'b0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .busy(busy[2]), .done(done[2]),
    .pass(pass[2]), .err_count(err[2]), .fail_a(fa[2]), .fail_b(fb[2]),
    .fail_op(fop[2]), .fail_y(fy[2]), .alu_a(aa[2]), .alu_b(ab[2]),
    .alu_op(aop[2]), .alu_y(ay[2]));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // Scoreboard entry: final result and run length expected for one DUT run.
  typedef struct {
    logic [31:0] err, fa, fb, fop, fy, pass, lat;
  } res_t;
  res_t exp_q[$];

  function automatic res_t model_run(input logic flt, input bit stop, input int settle);
    res_t r;
    int n;
    logic [10:0] iv;
    logic [3:0]  a, b, y;
    logic [2:0]  op;
    r.err = 0; r.fa = 0; r.fb = 0; r.fop = 0; r.fy = 0;
    n = 0;
    for (int i = 0; i < 2048; i++) begin
      iv = 11'(i);
      a = iv[10:7]; b = iv[6:3]; op = iv[2:0];
      y = alu_model(a, b, op, flt);
      n++;
      if (y != tb_ref(a, b, op)) begin
        if (r.err == 0) begin
          r.fa = 32'(a); r.fb = 32'(b); r.fop = 32'(op); r.fy = 32'(y);
        end
        if (r.err < 4095) r.err = r.err + 1;
        if (stop) break;
      end
    end
    r.lat  = 32'(n * (settle + 1));
    r.pass = (r.err == 0) ? 32'd1 : 32'd0;
    return r;
  endfunction

  // Monitor: done-rise cycle, per-vector hold length and sweep order.
  int          done_cyc [3] = '{0, 0, 0};
  logic        done_prev [3] = '{1'b0, 1'b0, 1'b0};
  logic [10:0] mprev [3] = '{11'd0, 11'd0, 11'd0};
  logic        in_run [3] = '{1'b0, 1'b0, 1'b0};
  int          hold [3] = '{0, 0, 0};
  int          hold_bad [3] = '{0, 0, 0};
  int          order_bad [3] = '{0, 0, 0};
  int          hold_seen [3] = '{0, 0, 0};
  int          settle_of [3] = '{1, 1, 3};

  always @(negedge clk) begin : mon
    logic [10:0] v;
    for (int d = 0; d < 3; d++) begin
      if (done[d] && !done_prev[d]) done_cyc[d] = cyc;
      done_prev[d] = done[d];
      v = {aa[d], ab[d], aop[d]};
      if (v != mprev[d]) begin
        if (busy[d] && in_run[d]) begin
          hold_seen[d]++;
          if (hold[d] != settle_of[d] + 1) hold_bad[d]++;
          if (v != mprev[d] + 11'd1) order_bad[d]++;
        end
        in_run[d] = busy[d];
        hold[d]   = 1;
        mprev[d]  = v;
      end else begin
        hold[d]++;
        if (!busy[d]) in_run[d] = 1'b0;
      end
    end
  end

  task automatic run_phase(input logic flt, input bit pulse, input string ph);
    int   c0;
    int   t;
    res_t e;
    fault = flt;
    @(negedge clk);
    start = 3'b111;
    c0 = cyc + 1;
    @(negedge clk);
    start = 3'b000;
    exp_q.push_back(model_run(flt, 1'b0, 1));
    exp_q.push_back(model_run(flt, 1'b1, 1));
    exp_q.push_back(model_run(flt, 1'b0, 3));
    if (pulse) begin
      repeat (500) @(negedge clk);
      chk({ph, "_busy_mid"}, 32'(busy[0]), 1);
      start = 3'b101;
      @(negedge clk);
      start = 3'b000;
    end
    for (int d = 0; d < 3; d++) begin
      t = 0;
      while (!done[d] && t < 20000) begin
        @(negedge clk);
        t++;
      end
      chk($sformatf("%s_d%0d_done", ph, d), 32'(done[d]), 1);
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("%s_d%0d_len", ph, d), 32'(done_cyc[d] - c0), e.lat);
      chk($sformatf("%s_d%0d_err", ph, d), 32'(err[d]), e.err);
      chk($sformatf("%s_d%0d_fail_a", ph, d), 32'(fa[d]), e.fa);
      chk($sformatf("%s_d%0d_fail_b", ph, d), 32'(fb[d]), e.fb);
      chk($sformatf("%s_d%0d_fail_op", ph, d), 32'(fop[d]), e.fop);
      chk($sformatf("%s_d%0d_fail_y", ph, d), 32'(fy[d]), e.fy);
      chk($sformatf("%s_d%0d_pass", ph, d), 32'(pass[d]), e.pass);
      chk($sformatf("%s_d%0d_busy", ph, d), 32'(busy[d]), 0);
    end
  endtask

  task automatic chk_zero(input string ph);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_d%0d_busy", ph, d), 32'(busy[d]), 0);
      chk($sformatf("%s_d%0d_done", ph, d), 32'(done[d]), 0);
      chk($sformatf("%s_d%0d_pass", ph, d), 32'(pass[d]), 0);
      chk($sformatf("%s_d%0d_err", ph, d), 32'(err[d]), 0);
      chk($sformatf("%s_d%0d_vec", ph, d), 32'({aa[d], ab[d], aop[d]}), 0);
      chk($sformatf("%s_d%0d_fail", ph, d), 32'({fa[d], fb[d], fop[d], fy[d]}), 0);
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_zero("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy[0]), 0);
    chk("idle_done", 32'(done[0]), 0);

    run_phase(1'b0, 1'b1, "clean");
    run_phase(1'b1, 1'b1, "fault");
    chk("fault_err224", 32'(err[0]), 224);
    chk("fault_stop_err", 32'(err[1]), 1);
    chk("fault_stop_fb", 32'(fb[1]), 1);
    chk("fault_stop_fy", 32'(fy[1]), 1);
    run_phase(1'b1, 1'b0, "rerun");

    // Reset mid-run, between clock edges.
    fault = 1'b0;
    @(negedge clk);
    start = 3'b111;
    @(negedge clk);
    start = 3'b000;
    repeat (98) @(negedge clk);
    chk("pre_rst_busy", 32'(busy[0]), 1);
    chk("pre_rst_vec_nz", 32'({aa[0], ab[0], aop[0]} != 11'd0), 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_phase(1'b0, 1'b0, "post_rst");

    for (int d = 0; d < 3; d++) begin
      chk($sformatf("hold_bad_d%0d", d), 32'(hold_bad[d]), 0);
      chk($sformatf("order_bad_d%0d", d), 32'(order_bad[d]), 0);
    end
    chk("hold_seen_d2", 32'(hold_seen[2] > 6000), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
